mcu_bus_ctrl: RTL and testbench



---
 rtl/mcu_bus_pkg.sv | 23 ++
 rtl/mcu_bus_ctrl_if.sv | 47 ++++
 rtl/mcu_bus_decoder.sv | 41 ++++
 rtl/mcu_bus_ctrl.sv | 130 +++++++++++++
 tb/tb_mcu_bus_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mcu_bus_pkg.sv
// Shared types and constants for the MCU bus controller: FSM states,
// the default memory/LED/TTY address map and the timeout counter width.
package mcu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [31:0] MEM_BASE  = 32'h0000_0000;
    localparam logic [31:0] LB_BASE   = 32'hFF00_0000;
    localparam logic [31:0] TTY_BASE  = 32'hFF00_0004;
    localparam logic [31:0] TTY_LIMIT = 32'hFF00_0008;

    localparam int TIMEOUT_CNT_W = 8;

    // Width of a binary slave index; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mcu_bus_ctrl_if.sv
// Bus bundle between the RV32I master, the bus controller and its slaves.
// Handshake: master holds m_req_i and fields until the one-cycle m_ready_o strobe; a slave holds nothing and answers the one-hot s_req_o with s_ack_i.
interface mcu_bus_ctrl_if #(
    parameter int NUM_SLAVES = 3,
    parameter int AW         = 32,
    parameter int DW         = 32
);
    import mcu_bus_pkg::*;

    logic                     m_req_i;
    logic [AW-1:0]            m_addr_i;
    logic                     m_we_i;
    logic [DW/8-1:0]          m_be_i;
    logic [DW-1:0]            m_wdata_i;
    logic                     m_ready_o;
    logic [DW-1:0]            m_rdata_o;
    logic                     m_err_o;

    logic [NUM_SLAVES-1:0]    s_req_o;
    logic [AW-1:0]            s_addr_o;
    logic                     s_we_o;
    logic [DW/8-1:0]          s_be_o;
    logic [DW-1:0]            s_wdata_o;
    logic [NUM_SLAVES*DW-1:0] s_rdata_i;
    logic [NUM_SLAVES-1:0]    s_ack_i;

    state_t                   dbg_state;

    modport ctrl (
        input  m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i,
        output m_ready_o, m_rdata_o, m_err_o,
        output s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o,
        input  s_rdata_i, s_ack_i,
        output dbg_state
    );

    modport master (
        output m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i,
        input  m_ready_o, m_rdata_o, m_err_o
    );

    modport slave (
        input  s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o,
        output s_rdata_i, s_ack_i
    );

endinterface

// File: rtl/mcu_bus_decoder.sv
// Combinational address decoder: matches an address against per-slave
// [base, limit) windows, lowest index winning on overlap.
module mcu_bus_decoder
    import mcu_bus_pkg::*;
#(
    parameter int                       NUM_SLAVES = 3,
    parameter int                       AW         = 32,
    parameter logic [NUM_SLAVES*AW-1:0] SLV_BASE   = {TTY_BASE, LB_BASE, MEM_BASE},
    parameter logic [NUM_SLAVES*AW-1:0] SLV_LIMIT  = {TTY_LIMIT, TTY_BASE, LB_BASE},
    localparam int                      SEL_W      = sel_width(NUM_SLAVES)
) (
    input  logic [AW-1:0]         addr_i,
    output logic [NUM_SLAVES-1:0] hit_o,
    output logic [SEL_W-1:0]      sel_o,
    output logic                  miss_o
);

    logic [NUM_SLAVES-1:0] raw_hit;

    always_comb begin
        raw_hit = '0;
        hit_o   = '0;
        sel_o   = '0;
        miss_o  = 1'b1;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            raw_hit[i] = (addr_i >= SLV_BASE[i*AW +: AW]) &&
                         (addr_i <  SLV_LIMIT[i*AW +: AW]);
        end
        // Walk downwards so the lowest matching index is the one left standing.
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (raw_hit[i]) begin
                sel_o  = SEL_W'(i);
                miss_o = 1'b0;
            end
        end
        if (!miss_o) begin
            hit_o = NUM_SLAVES'(1) << sel_o;
        end
    end

endmodule

// File: rtl/mcu_bus_ctrl.sv
// Single-master, N-slave bus controller: decodes, forwards with req/ack,
// inserts wait states, times out silent slaves and registers the response.
module mcu_bus_ctrl
    import mcu_bus_pkg::*;
#(
    parameter int                       NUM_SLAVES  = 3,
    parameter int                       AW          = 32,
    parameter int                       DW          = 32,
    parameter logic [NUM_SLAVES*AW-1:0] SLV_BASE    = {TTY_BASE, LB_BASE, MEM_BASE},
    parameter logic [NUM_SLAVES*AW-1:0] SLV_LIMIT   = {TTY_LIMIT, TTY_BASE, LB_BASE},
    parameter int                       TIMEOUT_CYC = 15
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mcu_bus_ctrl_if.ctrl  bus
);

    localparam int BW    = DW / 8;
    localparam int SEL_W = sel_width(NUM_SLAVES);
    localparam logic [TIMEOUT_CNT_W-1:0] TO_LIM = TIMEOUT_CNT_W'(TIMEOUT_CYC);

    state_t                   state_q, state_d;
    logic [AW-1:0]            addr_q, addr_d;
    logic                     we_q, we_d;
    logic [BW-1:0]            be_q, be_d;
    logic [DW-1:0]            wdata_q, wdata_d;
    logic [SEL_W-1:0]         sel_q, sel_d;
    logic [DW-1:0]            rdata_q, rdata_d;
    logic                     err_q, err_d;
    logic [TIMEOUT_CNT_W-1:0] cnt_q, cnt_d;

    logic [NUM_SLAVES-1:0]    dec_hit;
    logic [SEL_W-1:0]         dec_sel;
    logic                     dec_miss;

    mcu_bus_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .AW         (AW),
        .SLV_BASE   (SLV_BASE),
        .SLV_LIMIT  (SLV_LIMIT)
    ) u_decoder (
        .addr_i (bus.m_addr_i),
        .hit_o  (dec_hit),
        .sel_o  (dec_sel),
        .miss_o (dec_miss)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.m_req_i) begin
                    addr_d  = bus.m_addr_i;
                    we_d    = bus.m_we_i;
                    be_d    = bus.m_be_i;
                    wdata_d = bus.m_wdata_i;
                    sel_d   = dec_sel;
                    err_d   = dec_miss;
                    rdata_d = '0;
                    cnt_d   = '0;
                    state_d = (|dec_hit) ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                // An ack in the final counted cycle still wins over the timeout.
                if (bus.s_ack_i[sel_q]) begin
                    rdata_d = we_q ? '0 : bus.s_rdata_i[int'(sel_q)*DW +: DW];
                    err_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == TO_LIM) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request and strobe are decoded from state flops, so reset clears them at once.
    assign bus.s_req_o   = (state_q == ACCESS) ? (NUM_SLAVES'(1) << sel_q) : '0;
    assign bus.s_addr_o  = addr_q;
    assign bus.s_we_o    = we_q;
    assign bus.s_be_o    = be_q;
    assign bus.s_wdata_o = wdata_q;
    assign bus.m_ready_o = (state_q == RESP);
    assign bus.m_rdata_o = rdata_q;
    assign bus.m_err_o   = err_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mcu_bus_ctrl.sv
// Self-checking bench for mcu_bus_ctrl: directed map/boundary/timeout/reset
// cases plus randomized accesses scored against a behavioural bus model.
module tb_mcu_bus_ctrl;
    import mcu_bus_pkg::*;

    localparam int NS = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int TO = 15;
    localparam int EW = 8 + 8 + 1 + DW;

    localparam logic [AW-1:0] WIN_BASE [NS] = '{32'h0000_0000, 32'hFF00_0000, 32'hFF00_0004};
    localparam logic [AW-1:0] WIN_LIM  [NS] = '{32'hFF00_0000, 32'hFF00_0004, 32'hFF00_0008};

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    mcu_bus_ctrl_if #(.NUM_SLAVES(NS), .AW(AW), .DW(DW)) bus ();

    mcu_bus_ctrl #(
        .NUM_SLAVES  (NS),
        .AW          (AW),
        .DW          (DW),
        .SLV_BASE    ({32'hFF00_0004, 32'hFF00_0000, 32'h0000_0000}),
        .SLV_LIMIT   ({32'hFF00_0008, 32'hFF00_0004, 32'hFF00_0000}),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            req_cyc  = 0;
    int            sreq_cnt = 0;

    logic [NS-1:0] cur_onehot = '0;
    logic [AW-1:0] cur_addr   = '0;
    logic          cur_we     = 1'b0;
    logic [BW-1:0] cur_be     = '0;
    logic [DW-1:0] cur_wdata  = '0;

    // slave responder configuration
    bit            sl_ack_en = 1'b0;
    int            sl_wait   = 0;
    logic [DW-1:0] sl_data   = '0;
    bit            sl_stray  = 1'b0;
    int            acc_seen  = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic int model_decode(input logic [AW-1:0] a);
        for (int i = 0; i < NS; i++) begin
            if (a >= WIN_BASE[i] && a < WIN_LIM[i]) return i;
        end
        return -1;
    endfunction

    // ---------------- slave responder ----------------
    always @(negedge clk_i) begin
        logic [NS-1:0]    ack;
        logic [NS*DW-1:0] rd;
        ack = '0;
        rd  = '0;
        if (bus.s_req_o != '0) begin
            acc_seen = acc_seen + 1;
            for (int i = 0; i < NS; i++) begin
                if (bus.s_req_o[i]) begin
                    rd[i*DW +: DW] = sl_data;
                    ack[i] = sl_ack_en && (acc_seen == sl_wait + 1);
                end else begin
                    rd[i*DW +: DW] = $urandom;
                    ack[i] = sl_stray ? 1'($urandom_range(0, 1)) : 1'b0;
                end
            end
        end else begin
            acc_seen = 0;
        end
        bus.s_ack_i   = ack;
        bus.s_rdata_i = rd;
    end

    // ---------------- monitor ----------------
    always @(negedge clk_i) begin
        logic [EW-1:0] e;
        if (bus.s_req_o != '0) begin
            sreq_cnt = sreq_cnt + 1;
            check("s_req_onehot", 96'(bus.s_req_o), 96'(cur_onehot));
            check("s_fields", 96'({bus.s_addr_o, bus.s_we_o, bus.s_be_o, bus.s_wdata_o}),
                  96'({cur_addr, cur_we, cur_be, cur_wdata}));
        end
        if (bus.m_ready_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 96'(bus.m_ready_o), 96'(0));
            end else begin
                e = exp_q.pop_front();
                check("rdata", 96'(bus.m_rdata_o), 96'(e[DW-1:0]));
                check("err", 96'(bus.m_err_o), 96'(e[DW]));
                check("latency", 96'(cyc - req_cyc), 96'(e[DW+8:DW+1]));
                check("access_cycles", 96'(sreq_cnt), 96'(e[DW+16:DW+9]));
            end
            sreq_cnt = 0;
        end else if (bus.s_req_o == '0) begin
            sreq_cnt = 0;
        end
    end

    // ---------------- driver ----------------
    task automatic run_txn(input logic [AW-1:0] addr, input logic we, input logic [BW-1:0] be,
                           input logic [DW-1:0] wdata, input bit ack_en, input int ack_wait,
                           input logic [DW-1:0] ack_data, input bit scramble, input bit stray);
        int            idx;
        logic          err;
        logic [DW-1:0] rd;
        int            lat;
        int            acc;
        bit            done;
        idx = model_decode(addr);
        if (idx < 0) begin
            err = 1'b1; rd = '0; lat = 1; acc = 0;
        end else if (ack_en && (ack_wait + 1 <= TO)) begin
            err = 1'b0; rd = we ? '0 : ack_data; lat = ack_wait + 2; acc = ack_wait + 1;
        end else begin
            err = 1'b1; rd = '0; lat = TO + 1; acc = TO;
        end
        exp_q.push_back({8'(acc), 8'(lat), err, rd});

        sl_ack_en  = ack_en;
        sl_wait    = ack_wait;
        sl_data    = ack_data;
        sl_stray   = stray;
        cur_onehot = (idx < 0) ? '0 : NS'(1 << idx);
        cur_addr   = addr;
        cur_we     = we;
        cur_be     = be;
        cur_wdata  = wdata;

        bus.m_req_i   = 1'b1;
        bus.m_addr_i  = addr;
        bus.m_we_i    = we;
        bus.m_be_i    = be;
        bus.m_wdata_i = wdata;
        req_cyc       = cyc;

        if (scramble) begin
            @(posedge clk_i);
            #1;
            bus.m_addr_i  = $urandom;
            bus.m_we_i    = ~we;
            bus.m_be_i    = BW'($urandom);
            bus.m_wdata_i = $urandom;
        end

        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk_i);
            if (bus.m_ready_o) done = 1'b1;
        end
        if (!done) begin
            check("ready_timeout", 96'(bus.m_ready_o), 96'(1));
            exp_q.delete();
        end
        bus.m_req_i = 1'b0;
        @(negedge clk_i);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [AW-1:0] a;
        rst_i         = 1'b1;
        bus.m_req_i   = 1'b0;
        bus.m_addr_i  = '0;
        bus.m_we_i    = 1'b0;
        bus.m_be_i    = '0;
        bus.m_wdata_i = '0;

        repeat (3) @(negedge clk_i);
        check("rst_ready", 96'(bus.m_ready_o), 96'(0));
        check("rst_s_req", 96'(bus.s_req_o), 96'(0));
        check("rst_m_data_err", 96'({bus.m_rdata_o, bus.m_err_o}), 96'(0));
        check("rst_s_fields", 96'({bus.s_addr_o, bus.s_we_o, bus.s_be_o, bus.s_wdata_o}), 96'(0));
        check("rst_state", 96'(bus.dbg_state), 96'(IDLE));
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        // Directed: read slave 0, write TTY with waits, unmapped, timeout, late ack.
        run_txn(32'h0000_0100, 1'b0, 4'hF, 32'h0, 1'b1, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        run_txn(32'hFF00_0004, 1'b1, 4'b0001, 32'h41, 1'b1, 3, 32'h1234_5678, 1'b0, 1'b0);
        run_txn(32'hFF00_0010, 1'b0, 4'hF, 32'h0, 1'b1, 0, 32'h5555_AAAA, 1'b0, 1'b0);
        run_txn(32'hFF00_0000, 1'b0, 4'hF, 32'h0, 1'b0, 0, 32'h0, 1'b0, 1'b0);
        run_txn(32'hFF00_0000, 1'b0, 4'hF, 32'h0, 1'b1, TO - 1, 32'hCAFE_F00D, 1'b0, 1'b0);
        run_txn(32'hFF00_0000, 1'b0, 4'hF, 32'h0, 1'b1, TO, 32'hCAFE_F00D, 1'b0, 1'b0);

        // Boundaries, zero byte-enables and a stray ack from a non-selected slave.
        run_txn(32'hFEFF_FFFF, 1'b0, 4'h0, 32'h0, 1'b1, 1, 32'h0BAD_0001, 1'b0, 1'b0);
        run_txn(32'hFF00_0000, 1'b0, 4'hF, 32'h0, 1'b1, 4, 32'h0BAD_0002, 1'b0, 1'b1);
        run_txn(32'hFF00_0003, 1'b1, 4'hC, 32'h77, 1'b1, 1, 32'h0BAD_0003, 1'b0, 1'b0);
        run_txn(32'hFF00_0007, 1'b0, 4'hF, 32'h0, 1'b1, 1, 32'h0BAD_0004, 1'b0, 1'b1);
        run_txn(32'hFF00_0008, 1'b0, 4'hF, 32'h0, 1'b1, 1, 32'h0BAD_0005, 1'b0, 1'b0);
        run_txn(32'h0000_0040, 1'b0, 4'hF, 32'h0, 1'b1, 2, 32'h600D_0006, 1'b1, 1'b1);

        // Asynchronous reset in the middle of an ACCESS: request vanishes, no strobe.
        sl_ack_en     = 1'b0;
        sl_stray      = 1'b0;
        cur_onehot    = 3'b010;
        cur_addr      = 32'hFF00_0000;
        cur_we        = 1'b0;
        cur_be        = 4'hF;
        cur_wdata     = 32'h0;
        bus.m_addr_i  = 32'hFF00_0000;
        bus.m_we_i    = 1'b0;
        bus.m_be_i    = 4'hF;
        bus.m_wdata_i = 32'h0;
        bus.m_req_i   = 1'b1;
        repeat (4) @(negedge clk_i);
        check("pre_rst_s_req", 96'(bus.s_req_o), 96'(3'b010));
        #2 rst_i = 1'b1;
        #1;
        check("async_rst_s_req", 96'(bus.s_req_o), 96'(0));
        check("async_rst_ready", 96'(bus.m_ready_o), 96'(0));
        bus.m_req_i = 1'b0;
        #1 rst_i = 1'b0;
        repeat (20) @(negedge clk_i);
        run_txn(32'hFF00_0004, 1'b0, 4'hF, 32'h0, 1'b1, 0, 32'h0000_0042, 1'b0, 1'b0);

        // Randomized accesses around the map edges and in open space.
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 5))
                0:       a = 32'($urandom_range(0, 32'h0000_FFFF));
                1:       a = 32'hFF00_0000 + 32'($urandom_range(0, 15));
                2:       a = 32'hFEFF_FFF0 + 32'($urandom_range(0, 15));
                3:       a = $urandom;
                4:       a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: a = 32'hFF00_0000 + 32'($urandom_range(0, 7));
            endcase
            run_txn(a, 1'($urandom_range(0, 1)), BW'($urandom), $urandom,
                    $urandom_range(0, 9) != 0, int'($urandom_range(0, 18)), $urandom,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk_i);
        check("exp_q_drained", 96'(exp_q.size()), 96'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
